hilo_mul_ctrl: RTL and testbench
================================

// Module: hilo_mul_ctrl
// PURPOSE
//  Sequencer for the HI/LO multiply unit serving MULT/MFHI/MFLO/MTHI/MTLO in the EX stage.
//  Runs a signed 32x32 MULT as a 32-iteration shift-add and owns the HI/LO registers.
//  Raises a pipeline stall when a HI/LO-class instruction meets a busy unit.
//  The ctrl decoder gates issue; MFHI/MFLO results return via hilo_rdata for RegWr writeback.
// PARAMETERS
//  DW      32   operand width; HI and LO are DW bits each
//  CNT_W   5    iteration counter width; log2(DW)
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    asynchronous, active-low reset
//  issue_i      in   1    EX holds a valid op=000000 HI/LO-class instruction
//  kill_i       in   1    EX instruction is flushed; blocks acceptance of issue_i
//  func_i       in   6    func field: MULT 011000, MFHI 010000, MFLO 010010, MTHI 010001, MTLO 010011
//  rs_i         in   DW   rs operand (multiplicand; MTHI/MTLO source)
//  rt_i         in   DW   rt operand (multiplier)
//  stall_o      out  1    freeze IF/ID/EX this cycle; combinational
//  busy_o       out  1    state != IDLE
//  hilo_rdata_o out  DW   HI for MFHI, LO for MFLO, 0 otherwise; combinational
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, HI=LO=0, cnt=0, acc=0, busy_o=0, stall_o=0.
//  - Reset mid-MULT aborts the operation; HI/LO read 0 afterwards.
//  accept = issue_i & ~kill_i & (state==IDLE); unknown func values are ignored (no state change).
//  FSM states:
//  - IDLE: accept&MULT -> RUN. Latch |rs| and |rt|, sign = rs[31]^rt[31], acc=0, cnt=0.
//  - IDLE: accept&MTHI -> HI<=rs_i at the next edge. accept&MTLO -> LO<=rs_i. Both single-cycle.
//  - IDLE: MFHI/MFLO read HI/LO combinationally, no stall.
//  - RUN: each cycle, if multiplier[0] then add multiplicand into acc upper half.
//  - RUN: then shift {acc,multiplier} right by 1 and cnt<=cnt+1. When cnt==DW-1 -> FIX.
//  - FIX: {HI,LO} <= sign ? -acc64 : acc64 (two's complement over 64 bits); -> IDLE.
//  Latency: MULT accepted at edge 0; RUN covers edges 1..32; HI/LO updated at edge 33.
//  - A dependent MFLO reads the result in the cycle after edge 33.
//  Stall: stall_o = issue_i & ~kill_i & busy_o; any HI/LO-class func stalls, MULT included.
//  - Non-HI/LO instructions never stall; unrelated instructions proceed under a running MULT.
//  - A MULT/MT/MF presented in the FIX cycle stalls one cycle, then is accepted from IDLE.
//  - kill_i while RUN/FIX does not abort the multiply; it only suppresses the new request.
//  Width rules:
//  - |x| of 0x80000000 = 0x80000000 as unsigned; all arithmetic is on 33-bit unsigned.
//  - Final negate is over 64 bits; a zero product is never negative.
//  hilo_rdata_o always shows the committed HI/LO, never partial acc.
//  A stalled MF therefore reads the new value once the unit is IDLE.
// STRUCTURE
//  Shared package (mips_defs): func codes MULT/MFHI/MFLO/MTHI/MTLO, DW, HI/LO FSM state encoding.
//  - The same func codes are used by ctrl.
//  Sub-module mul_shift_add: acc/multiplier registers, adder and shifter only.
//  - Ports: clk, rst_n, load, step, a, b, prod.
//  hilo_mul_ctrl keeps the FSM, counter, sign fix, HI/LO registers, stall and read mux.
// TESTING
//  1. MULT rs=7, rt=0xFFFFFFFD -> busy 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB after edge 33.
//  2. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
//     MULT 0x80000000 x 1 -> HI=0xFFFFFFFF, LO=0x80000000.
//  3. MULT 5x6, then MFLO issued 3 cycles later
//     -> stall_o=1 through the FIX cycle, then hilo_rdata_o=30; stall_o=0.
//  4. IDLE: MTHI rs=0x1234 then MFHI -> no stall; hilo_rdata_o=0x1234.
//     MTLO with kill_i=1 -> LO unchanged.
//  5. MULT with kill_i=1 -> stays IDLE, busy_o=0.
//     MULT in FIX cycle -> one stall cycle, then a second 33-cycle run.
//  6. rst_n low at RUN cycle 10 -> immediately IDLE, HI=LO=0, stall_o=0.
//     Next MULT 3x4 -> LO=12.

Source files
------------

// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
// Shared definitions for the EX-stage HI/LO multiply unit and the ctrl
// decoder: datapath width, iteration counter width, the func-field codes of
// the HI/LO-class instructions, and the HI/LO sequencer state encoding.
// ---------------------------------------------------------------------------
package mips_defs;

   localparam int HL_DW    = 32;
   localparam int HL_CNT_W = 5;

   // func field values of the op=000000 HI/LO-class instructions
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MTLO = 6'b010011;

   typedef enum logic [1:0] {
      HL_IDLE = 2'd0,
      HL_RUN  = 2'd1,
      HL_FIX  = 2'd2
   } hilo_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// ---------------------------------------------------------------------------
// mul_shift_add
// Unsigned shift-add multiplier datapath. Holds the multiplicand and a
// 2*DW-bit accumulator whose lower half starts out as the multiplier. Each
// step adds the multiplicand into the upper half when the current multiplier
// bit is set, then shifts the whole {acc, multiplier} pair right by one.
// After DW steps the accumulator holds the full unsigned product.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   load   in   1      capture a/b, clear the upper accumulator half
//   step   in   1      perform one add/shift iteration
//   a      in   DW     unsigned multiplicand
//   b      in   DW     unsigned multiplier
//   prod   out  2*DW   current accumulator contents
// ---------------------------------------------------------------------------
module mul_shift_add #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [2*DW-1:0] prod
);

   logic [DW-1:0]   mcand_q;
   logic [2*DW-1:0] acc_q;
   logic [DW:0]     upper_sum;

   // The upper half needs one extra bit so the carry out of the add is kept
   // and shifted down into bit 2*DW-1 rather than being lost.
   always_comb begin
      upper_sum = {1'b0, acc_q[2*DW-1:DW]};
      if (acc_q[0]) begin
         upper_sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, mcand_q};
      end
   end

   // Accumulator and multiplicand registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         acc_q   <= '0;
      end else if (load) begin
         mcand_q <= a;
         acc_q   <= {{DW{1'b0}}, b};
      end else if (step) begin
         acc_q   <= {upper_sum, acc_q[DW-1:1]};
      end
   end

   assign prod = acc_q;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mul_ctrl
// HI/LO multiply unit sequencer for the EX stage. Executes MULT as a signed
// DWxDW multiply (magnitudes through an unsigned shift-add core, sign applied
// at the end), owns the HI/LO registers for MTHI/MTLO, serves MFHI/MFLO reads
// combinationally, and stalls the front of the pipe when a HI/LO-class
// instruction arrives while a multiply is in flight.
//
// Ports
//   clk           in   1    rising-edge clock
//   rst_n         in   1    asynchronous active-low reset
//   issue_i       in   1    EX holds a valid HI/LO-class instruction
//   kill_i        in   1    EX instruction flushed; suppresses acceptance
//   func_i        in   6    func field (MULT/MFHI/MFLO/MTHI/MTLO)
//   rs_i          in   DW   multiplicand; MTHI/MTLO source
//   rt_i          in   DW   multiplier
//   stall_o       out  1    freeze IF/ID/EX this cycle
//   busy_o        out  1    multiply in progress (RUN or FIX)
//   hilo_rdata_o  out  DW   HI for MFHI, LO for MFLO, else 0
// ---------------------------------------------------------------------------
module hilo_mul_ctrl
   import mips_defs::*;
#(
   parameter int DW    = HL_DW,
   parameter int CNT_W = HL_CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_i,
   input  logic          kill_i,
   input  logic [5:0]    func_i,
   input  logic [DW-1:0] rs_i,
   input  logic [DW-1:0] rt_i,
   output logic          stall_o,
   output logic          busy_o,
   output logic [DW-1:0] hilo_rdata_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

   hilo_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             sign_q;
   logic [DW-1:0]    hi_q, lo_q;

   logic             accept;
   logic             is_mult, is_mthi, is_mtlo;
   logic             load, step, commit;
   logic [2*DW-1:0]  prod;
   logic [2*DW-1:0]  prod_fix;

   // Two's complement magnitude. The most negative value maps onto itself,
   // which is its correct magnitude once read as unsigned.
   function automatic logic [DW-1:0] mag(input logic [DW-1:0] x);
      return x[DW-1] ? (~x + DW'(1)) : x;
   endfunction

   assign is_mult = (func_i == FN_MULT);
   assign is_mthi = (func_i == FN_MTHI);
   assign is_mtlo = (func_i == FN_MTLO);

   assign busy_o  = (state_q != HL_IDLE);
   assign accept  = issue_i & ~kill_i & ~busy_o;
   assign stall_o = issue_i & ~kill_i & busy_o;

   mul_shift_add #(.DW(DW)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .step  (step),
      .a     (mag(rs_i)),
      .b     (mag(rt_i)),
      .prod  (prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE starts a multiply on an accepted MULT, RUN
   // iterates DW times, FIX writes the signed result and returns to IDLE.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      commit  = 1'b0;
      case (state_q)
         HL_IDLE: begin
            if (accept && is_mult) begin
               load    = 1'b1;
               state_d = HL_RUN;
            end
         end
         HL_RUN: begin
            step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = HL_FIX;
            end
         end
         HL_FIX: begin
            commit  = 1'b1;
            state_d = HL_IDLE;
         end
         default: begin
            state_d = HL_IDLE;
         end
      endcase
   end

   // Iteration counter and result sign, both captured when MULT is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sign_q <= 1'b0;
      end else if (load) begin
         cnt_q  <= '0;
         sign_q <= rs_i[DW-1] ^ rt_i[DW-1];
      end else if (step) begin
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

   // Negation over the full 2*DW bits; negating a zero product yields zero,
   // so a zero result never comes out negative.
   assign prod_fix = sign_q ? ((~prod) + (2*DW)'(1)) : prod;

   // HI/LO registers: written by the multiply commit or by MTHI/MTLO from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         hi_q <= prod_fix[2*DW-1:DW];
         lo_q <= prod_fix[DW-1:0];
      end else if (accept) begin
         if (is_mthi) begin
            hi_q <= rs_i;
         end
         if (is_mtlo) begin
            lo_q <= rs_i;
         end
      end
   end

   // Read mux only ever shows committed HI/LO, never the partial accumulator.
   always_comb begin
      hilo_rdata_o = '0;
      if (func_i == FN_MFHI) begin
         hilo_rdata_o = hi_q;
      end else if (func_i == FN_MFLO) begin
         hilo_rdata_o = lo_q;
      end
   end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mul_ctrl
// Self-checking bench for hilo_mul_ctrl. Expected products come from a signed
// 64-bit reference multiply and are queued when a MULT is issued, then popped
// and compared when the result is read back through MFHI/MFLO.
// ---------------------------------------------------------------------------
module tb_hilo_mul_ctrl;

   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MTLO = 6'b010011;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        issue = 1'b0;
   logic        kill  = 1'b0;
   logic [5:0]  func  = 6'd0;
   logic [31:0] rs    = 32'd0;
   logic [31:0] rt    = 32'd0;
   logic        stall;
   logic        busy;
   logic [31:0] rdata;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [63:0] expQ[$];

   hilo_mul_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_i      (issue),
      .kill_i       (kill),
      .func_i       (func),
      .rs_i         (rs),
      .rt_i         (rt),
      .stall_o      (stall),
      .busy_o       (busy),
      .hilo_rdata_o (rdata)
   );

   always #5 clk = ~clk;

   // Reference signed multiply on 64-bit integers.
   function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
      longint pa;
      longint pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   task automatic applyStimulus(input logic iss, input logic kl, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b);
      issue = iss;
      kill  = kl;
      func  = fn;
      rs    = a;
      rt    = b;
   endtask

   // Issues a MULT for one cycle; returns just after the accepting edge.
   task automatic startMult(input logic [31:0] a, input logic [31:0] b, input bit doPush);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MULT, a, b);
      if (doPush) expQ.push_back(refMul(a, b));
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
   endtask

   // Counts busy cycles until the unit returns to IDLE, bounded.
   task automatic waitIdle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
      testsRun++;
      if (cycles >= 200) begin
         testsFailed++;
         $display("[TB] FAIL wait_idle: busy still %b after %0d cycles, need 0", busy, cycles);
      end
   endtask

   // Reads HI then LO within one low clock phase.
   task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo, output logic st);
      applyStimulus(1'b1, 1'b0, F_MFHI, 32'd0, 32'd0);
      #1;
      hi = rdata;
      st = stall;
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'd0, 32'd0);
      #1;
      lo = rdata;
      st = st | stall;
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      logic        st;
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MULT, 32'd5, 32'd5);
      #1;
      testsRun++;
      if (busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_busy: got %b, need 0", busy);
      end
      testsRun++;
      if (stall !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_stall: got %b, need 0", stall);
      end
      readHiLo(hi, lo, st);
      testsRun++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_hilo: got %h_%h, need 0_0", hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mult_basic();
      int          cyc;
      logic [31:0] hi, lo;
      logic        st;
      logic [63:0] exp;
      startMult(32'd7, 32'hFFFFFFFD, 1'b1);
      waitIdle(cyc);
      testsRun++;
      if (cyc != 33) begin
         testsFailed++;
         $display("[TB] FAIL mult_busy_cycles: got %0d, need 33", cyc);
      end
      readHiLo(hi, lo, st);
      exp = expQ.pop_front();
      testsRun++;
      if ({hi, lo} !== exp) begin
         testsFailed++;
         $display("[TB] FAIL mult_7x-3: got %h_%h, need %h", hi, lo, exp);
      end
      testsRun++;
      if (st !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL mf_idle_stall: got %b, need 0", st);
      end
   endtask

   task automatic test_mult_corners();
      logic [31:0] ta[8];
      logic [31:0] tb[8];
      int          cyc;
      logic [31:0] hi, lo;
      logic        st;
      logic [63:0] exp;
      ta[0] = 32'h80000000; tb[0] = 32'h80000000;
      ta[1] = 32'h80000000; tb[1] = 32'h00000001;
      ta[2] = 32'h00000000; tb[2] = 32'hFFFFFFFB;
      ta[3] = 32'hFFFFFFFF; tb[3] = 32'hFFFFFFFF;
      ta[4] = 32'h7FFFFFFF; tb[4] = 32'h80000000;
      for (int i = 5; i < 8; i++) begin
         ta[i] = $urandom;
         tb[i] = $urandom;
      end
      for (int i = 0; i < 8; i++) begin
         startMult(ta[i], tb[i], 1'b1);
         waitIdle(cyc);
         readHiLo(hi, lo, st);
         exp = expQ.pop_front();
         testsRun++;
         if ({hi, lo} !== exp) begin
            testsFailed++;
            $display("[TB] FAIL mult_corner[%0d] %h*%h: got %h_%h, need %h",
                     i, ta[i], tb[i], hi, lo, exp);
         end
      end
   endtask

   task automatic test_stall_mflo();
      int          stalls;
      logic [31:0] firstRd;
      logic [63:0] exp;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MTLO, 32'h0000DEAD, 32'd0);
      startMult(32'd5, 32'd6, 1'b1);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'd0, 32'd0);
      #1;
      firstRd = rdata;
      stalls  = 0;
      while (stall === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      exp = expQ.pop_front();
      testsRun++;
      if (firstRd !== 32'h0000DEAD) begin
         testsFailed++;
         $display("[TB] FAIL mflo_during_run: got %h, need 0000dead", firstRd);
      end
      testsRun++;
      if (stalls != 31) begin
         testsFailed++;
         $display("[TB] FAIL mflo_stall_cycles: got %0d, need 31", stalls);
      end
      testsRun++;
      if (rdata !== exp[31:0]) begin
         testsFailed++;
         $display("[TB] FAIL mflo_after_stall: got %h, need %h", rdata, exp[31:0]);
      end
      applyStimulus(1'b1, 1'b0, F_MFHI, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (rdata !== exp[63:32]) begin
         testsFailed++;
         $display("[TB] FAIL mfhi_after_stall: got %h, need %h", rdata, exp[63:32]);
      end
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
   endtask

   task automatic test_mt_mf();
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MTHI, 32'h00001234, 32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MFHI, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (stall !== 1'b0 || rdata !== 32'h00001234) begin
         testsFailed++;
         $display("[TB] FAIL mthi_mfhi: got stall=%b data=%h, need stall=0 data=00001234", stall, rdata);
      end
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MTLO, 32'h0000ABCD, 32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, F_MTLO, 32'h00005555, 32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (rdata !== 32'h0000ABCD) begin
         testsFailed++;
         $display("[TB] FAIL mtlo_killed: got %h, need 0000abcd", rdata);
      end
      applyStimulus(1'b1, 1'b0, F_MFHI, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (rdata !== 32'h00001234) begin
         testsFailed++;
         $display("[TB] FAIL mtlo_hi_untouched: got %h, need 00001234", rdata);
      end
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
   endtask

   task automatic test_kill_mult();
      int          cyc;
      logic [31:0] hi, lo;
      logic        st;
      logic [63:0] exp;
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, F_MULT, 32'd9, 32'd9);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL killed_mult_busy: got %b, need 0", busy);
      end
      startMult(32'd9, 32'd9, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, F_MULT, 32'd2, 32'd2);
      #1;
      testsRun++;
      if (stall !== 1'b0 || busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL kill_during_run: got stall=%b busy=%b, need stall=0 busy=1", stall, busy);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
      waitIdle(cyc);
      readHiLo(hi, lo, st);
      exp = expQ.pop_front();
      testsRun++;
      if ({hi, lo} !== exp) begin
         testsFailed++;
         $display("[TB] FAIL mult_after_kill: got %h_%h, need %h", hi, lo, exp);
      end
   endtask

   task automatic test_back_to_back();
      int          cyc;
      logic [31:0] hi, lo;
      logic        st;
      logic [63:0] exp;
      startMult(32'd2, 32'd3, 1'b0);
      repeat (32) @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MULT, 32'hFFFFFFFC, 32'd5);
      expQ.push_back(refMul(32'hFFFFFFFC, 32'd5));
      #1;
      testsRun++;
      if (stall !== 1'b1 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL fix_cycle_mult: got stall=%b data=%h, need stall=1 data=0", stall, rdata);
      end
      @(negedge clk);
      #1;
      testsRun++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL after_fix_idle: got stall=%b busy=%b, need 0 0", stall, busy);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
      waitIdle(cyc);
      testsRun++;
      if (cyc != 33) begin
         testsFailed++;
         $display("[TB] FAIL second_run_cycles: got %0d, need 33", cyc);
      end
      readHiLo(hi, lo, st);
      exp = expQ.pop_front();
      testsRun++;
      if ({hi, lo} !== exp) begin
         testsFailed++;
         $display("[TB] FAIL back_to_back_result: got %h_%h, need %h", hi, lo, exp);
      end
   endtask

   task automatic test_reset_mid();
      int          cyc;
      logic [31:0] hi, lo;
      logic        st;
      logic [63:0] exp;
      startMult(32'h11111111, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      applyStimulus(1'b1, 1'b0, F_MULT, 32'd0, 32'd0);
      #1;
      testsRun++;
      if (stall !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL mid_run_stall: got %b, need 1", stall);
      end
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_state: got busy=%b stall=%b, need 0 0", busy, stall);
      end
      readHiLo(hi, lo, st);
      testsRun++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset_hilo: got %h_%h, need 0_0", hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      startMult(32'd3, 32'd4, 1'b1);
      waitIdle(cyc);
      readHiLo(hi, lo, st);
      exp = expQ.pop_front();
      testsRun++;
      if ({hi, lo} !== exp) begin
         testsFailed++;
         $display("[TB] FAIL mult_after_reset: got %h_%h, need %h", hi, lo, exp);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      test_reset();
      test_mult_basic();
      test_mult_corners();
      test_stall_mflo();
      test_mt_mf();
      test_kill_mult();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
